sockit_ghrd_debounce_pio: RTL and testbench



---
 rtl/sockit_ghrd_debounce_pio.sv | 121 ++++++++++++
 tb/tb_sockit_ghrd_debounce_pio.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sockit_ghrd_debounce_pio.sv
// Debounced input PIO for the lightweight HPS-to-FPGA bridge: two-flop sync, per-bit debounce,
// selectable edge capture with write-1-to-clear, per-bit interrupt mask and a raw diagnostic view.
module sockit_ghrd_debounce_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_dly_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_val;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // A restart on any return to the old level is what rejects glitches shorter than the window.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign edge_det = (stable_q & ~stable_dly_q & rise_en_q) |
                    (~stable_q & stable_dly_q & fall_en_q);

  always_comb begin
    irq_mask_d     = irq_mask_q;
    rise_en_d      = rise_en_q;
    fall_en_d      = fall_en_q;
    edge_capture_d = edge_capture_q;
    if (wr) begin
      unique case (address)
        3'd2:    irq_mask_d = wdata;
        3'd3:    rise_en_d = wdata;
        3'd4:    fall_en_d = wdata;
        3'd5:    edge_capture_d = edge_capture_q & ~wdata;
        default: ;
      endcase
    end
    // Set after clear so a coincident edge is never lost.
    edge_capture_d = edge_capture_d | edge_det;
  end

  always_comb begin
    rd_val = '0;
    unique case (address)
      3'd0:    rd_val = stable_q;
      3'd1:    rd_val = sync2_q;
      3'd2:    rd_val = irq_mask_q;
      3'd3:    rd_val = rise_en_q;
      3'd4:    rd_val = fall_en_q;
      3'd5:    rd_val = edge_capture_q;
      default: rd_val = '0;
    endcase
    readdata_d = 32'(rd_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= RESET_LEVEL;
      sync2_q        <= RESET_LEVEL;
      stable_q       <= RESET_LEVEL;
      stable_dly_q   <= RESET_LEVEL;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      rise_en_q      <= '0;
      fall_en_q      <= '1;
      readdata_q     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q        <= in_port;
      sync2_q        <= sync1_q;
      stable_q       <= stable_d;
      stable_dly_q   <= stable_q;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      rise_en_q      <= rise_en_d;
      fall_en_q      <= fall_en_d;
      readdata_q     <= readdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_sockit_ghrd_debounce_pio.sv
// Bench for sockit_ghrd_debounce_pio with a 4-cycle debounce window: a cycle-accurate vector
// table for reset and the basic debounce path, then directed sequences for the corner cases.
module tb_sockit_ghrd_debounce_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  sockit_ghrd_debounce_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in;
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rd;   // readdata seen after this row's clock edge
    logic        irq;  // irq seen after this row's clock edge
  } vec_t;

  localparam int NumVec = 18;
  vec_t vecs [NumVec];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic [3:0] in, input logic [2:0] a, input logic w,
                     input logic [31:0] wd);
    in_port    = in;
    address    = a;
    chipselect = w;
    write_n    = ~w;
    writedata  = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] in, input int n);
    for (int k = 0; k < n; k++) cyc(in, 3'd0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold(4'hF, 3);
    reset = 1'b0;
  endtask

  initial begin
    // Reset read-back of every address.
    vecs[0]  = '{4'hF, 3'd0, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[1]  = '{4'hF, 3'd1, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[2]  = '{4'hF, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{4'hF, 3'd3, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{4'hF, 3'd4, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[5]  = '{4'hF, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{4'hF, 3'd6, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{4'hF, 3'd7, 1'b0, 32'h0, 32'h0, 1'b0};
    // Bit0 falls: RAW follows after 2 edges, DATA 4 edges later, capture one edge after that.
    vecs[8]  = '{4'hE, 3'd0, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[9]  = '{4'hE, 3'd1, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[10] = '{4'hE, 3'd1, 1'b0, 32'h0, 32'hE, 1'b0};
    vecs[11] = '{4'hE, 3'd0, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[12] = '{4'hE, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[13] = '{4'hE, 3'd0, 1'b0, 32'h0, 32'hF, 1'b0};
    vecs[14] = '{4'hE, 3'd0, 1'b0, 32'h0, 32'hE, 1'b0};
    vecs[15] = '{4'hE, 3'd5, 1'b0, 32'h0, 32'h1, 1'b0};
    // Unmask bit0: irq rises as the mask write lands.
    vecs[16] = '{4'hE, 3'd2, 1'b1, 32'h1, 32'h0, 1'b1};
    vecs[17] = '{4'hE, 3'd2, 1'b0, 32'h0, 32'h1, 1'b1};

    in_port = 4'hF; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk);
    do_reset();
    chk("reset readdata", readdata, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);

    for (int i = 0; i < NumVec; i++) begin
      cyc(vecs[i].in, vecs[i].addr, vecs[i].wr, vecs[i].wd);
      chk($sformatf("vec%0d readdata", i), readdata, vecs[i].rd);
      chk($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].irq});
    end

    // Glitch rejection on bit1 and counter restart.
    cyc(4'hE, 3'd5, 1'b1, 32'h1);
    chk("w1c clears irq", {31'h0, irq}, 32'h0);
    hold(4'hC, 3);
    hold(4'hE, 8);
    cyc(4'hE, 3'd0, 1'b0, 32'h0);
    chk("glitch data", readdata, 32'hE);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("glitch capture", readdata, 32'h0);
    hold(4'hC, 2);
    hold(4'hE, 6);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("restart capture", readdata, 32'h0);
    hold(4'hC, 4);
    hold(4'hE, 8);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("4-cycle low captured", readdata, 32'h2);
    cyc(4'hE, 3'd0, 1'b0, 32'h0);
    chk("data after bit1 pulse", readdata, 32'hE);

    // Rising-only capture on bit2, W1C semantics.
    cyc(4'hE, 3'd3, 1'b1, 32'h4);
    cyc(4'hE, 3'd4, 1'b1, 32'h0);
    cyc(4'hE, 3'd2, 1'b1, 32'h4);
    cyc(4'hE, 3'd5, 1'b1, 32'hF);
    hold(4'hA, 8);
    hold(4'hE, 8);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("rise-only capture", readdata, 32'h4);
    chk("rise irq", {31'h0, irq}, 32'h1);
    cyc(4'hE, 3'd5, 1'b1, 32'h0);
    chk("w0 keeps irq", {31'h0, irq}, 32'h1);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("w0 keeps capture", readdata, 32'h4);
    cyc(4'hE, 3'd5, 1'b1, 32'h4);
    chk("w1 drops irq", {31'h0, irq}, 32'h0);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("w1 clears capture", readdata, 32'h0);

    // Clear and new edge on the same clock: the edge wins.
    cyc(4'hE, 3'd4, 1'b1, 32'hF);
    hold(4'hF, 8);
    cyc(4'hF, 3'd5, 1'b1, 32'hF);
    hold(4'hE, 6);
    cyc(4'hE, 3'd5, 1'b1, 32'h1);
    chk("capture before collision", readdata, 32'h0);
    cyc(4'hE, 3'd5, 1'b0, 32'h0);
    chk("set wins over clear", readdata, 32'h1);

    // Reset with a bit0 count at 2.
    hold(4'hF, 8);
    cyc(4'hF, 3'd5, 1'b1, 32'hF);
    hold(4'hE, 4);
    reset = 1'b1;
    cyc(4'hF, 3'd0, 1'b0, 32'h0);
    reset = 1'b0;
    chk("mid-reset readdata", readdata, 32'h0);
    chk("mid-reset irq", {31'h0, irq}, 32'h0);
    hold(4'hF, 6);
    cyc(4'hF, 3'd0, 1'b0, 32'h0);
    chk("post-reset data", readdata, 32'hF);
    cyc(4'hF, 3'd5, 1'b0, 32'h0);
    chk("post-reset capture", readdata, 32'h0);
    cyc(4'hF, 3'd4, 1'b0, 32'h0);
    chk("post-reset fall_en", readdata, 32'hF);
    chk("post-reset irq", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
